// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: drives imem, buffers {pc, instr} in a prefetch FIFO, hands off to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects halt fetch and set a sticky misalign_err.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       NOP     = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pc_buf    [FIFO_DEPTH];
    logic [31:0]      instr_buf [FIFO_DEPTH];

    logic        empty;
    logic        pop;
    logic        push;
    logic        halted;
    logic        target_ok;
    logic [31:0] target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    assign target_ok    = (redirect_pc[1:0] == 2'b00);
    assign halted       = misalign_q;
    assign misalign_err = misalign_q;

    // Sticky until reset; a later aligned redirect does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && !target_ok) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign target_ok    = 1'b1;
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign empty     = (count == '0);
    assign if_valid  = !empty && !redirect_valid;
    assign pop       = if_valid && id_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign push      = !redirect_valid && !halted && ((count < DEPTH_C) || pop);

    assign imem_addr = fetch_pc;
    assign if_instr  = empty ? NOP   : instr_buf[rd_ptr];
    assign if_pc     = empty ? '0    : pc_buf[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (target_ok) begin
                fetch_pc <= target_pc;
            end
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset: it is only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[wr_ptr]    <= fetch_pc;
            instr_buf[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scoreboard bench for if_fetch_unit: expected PCs are queued at stimulus time
// and compared against each decode handshake; instruction words come from a local memory model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0050_0113;
            32'h0000_0008: return 32'h0020_8463;
            32'h0000_000C: return 32'h00A0_0193;
            32'h0000_0010: return 32'h0140_0213;
            default:       return addr ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive inputs just after the falling edge, then let combinational outputs settle.
    task automatic apply_stimulus(input logic ready, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        id_ready       = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check_output(tag, {31'b0, if_valid}, 32'd0);
    endtask

    task automatic expect_deliver(input string tag);
        logic [31:0] exp_pc;
        check_output({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check_output({tag, "_sb_nonempty"}, {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
            exp_pc = exp_q.pop_front();
            check_output({tag, "_pc"}, if_pc, exp_pc);
            check_output({tag, "_instr"}, if_instr, mem_word(exp_pc));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        exp_q.delete();
        check_output("async_reset_valid", {31'b0, if_valid}, 32'd0);
        check_output("async_reset_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_valid", {31'b0, if_valid}, 32'd0);
        check_output("reset_instr", if_instr, 32'h0000_0013);
        check_output("reset_pc", if_pc, 32'h0);
        check_output("reset_addr", imem_addr, 32'h0);
        check_output("reset_misalign", {31'b0, misalign_err}, 32'd0);

        // Streaming from reset with decode always ready.
        exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
        exp_q.push_back(32'h0C); exp_q.push_back(32'h10);
        @(negedge clk);
        rst_n    = 1'b1;
        id_ready = 1'b1;
        #1;
        expect_idle("release_valid");
        repeat (5) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            expect_deliver("stream");
        end
        check_output("stream_drained", 32'(exp_q.size()), 32'd0);

        // Decode stalled: FIFO fills and fetch address holds.
        pulse_reset();
        id_ready = 1'b0;
        repeat (6) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("stall_addr", imem_addr, 32'h8);
        check_output("stall_pc", if_pc, 32'h0);
        check_output("stall_valid", {31'b0, if_valid}, 32'd1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("stall_addr_hold", imem_addr, 32'h8);
        exp_q.push_back(32'h00); exp_q.push_back(32'h04);
        exp_q.push_back(32'h08); exp_q.push_back(32'h0C);
        repeat (4) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            expect_deliver("drain");
        end

        // Redirect while FIFO holds pc 8 and C.
        pulse_reset();
        repeat (3) apply_stimulus(1'b0, 1'b0, 32'h0);
        exp_q.push_back(32'h00); exp_q.push_back(32'h04);
        repeat (2) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            expect_deliver("pre_redir");
        end
        exp_q.push_back(32'h10);
        apply_stimulus(1'b1, 1'b1, 32'h10);
        expect_idle("redir_cycle");
        check_output("redir_head_pc", if_pc, 32'h8);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_idle("redir_bubble");
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_deliver("redir_target");

        // Back-to-back redirects: last one wins.
        apply_stimulus(1'b1, 1'b1, 32'h20);
        expect_idle("b2b_first");
        apply_stimulus(1'b1, 1'b1, 32'h30);
        expect_idle("b2b_second");
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_idle("b2b_bubble");
        exp_q.push_back(32'h30); exp_q.push_back(32'h34);
        repeat (2) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            expect_deliver("b2b");
        end

        // Address wrap through 2^32.
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        expect_idle("wrap_redir");
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_idle("wrap_bubble");
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
        repeat (4) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            expect_deliver("wrap");
        end

        // Misaligned redirect; fetch_pc is 0xC at this point.
        apply_stimulus(1'b1, 1'b1, 32'h0000_0006);
        expect_idle("misalign_redir");
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (4) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            expect_idle("trap_halted");
        end
        check_output("trap_flag", {31'b0, misalign_err}, 32'd1);
        check_output("trap_addr_held", imem_addr, 32'hC);
        pulse_reset();
        check_output("trap_cleared", {31'b0, misalign_err}, 32'd0);
        id_ready = 1'b1;
        expect_idle("trap_release");
        exp_q.push_back(32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_deliver("trap_restart");
`else
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_idle("misalign_bubble");
        exp_q.push_back(32'h04); exp_q.push_back(32'h08);
        repeat (2) begin
            apply_stimulus(1'b1, 1'b0, 32'h0);
            expect_deliver("misalign_resume");
        end
        check_output("misalign_flag", {31'b0, misalign_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch front end. Drives the PC into the combinational instruction memory and captures the returned word. Buffers fetched words with their PC in a small prefetch FIFO. Hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute. A redirect flushes the prefetch buffer and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  byte address to instruction memory; equals fetch_pc, combinational.
- imem_rdata  in  32  instruction word; valid in the same cycle as imem_addr.
- if_valid  out  1  head entry available to decode.
- if_instr  out  32  head instruction.
- if_pc  out  32  PC of head instruction.
- id_ready  in  1  decode accepts head this cycle.
- redirect_valid  in  1  control-flow change request.
- redirect_pc  in  32  redirect target byte address.
- misalign_err  out  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, FIFO count=0, rd/wr pointers=0, misalign_err=0. Outputs: if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0.
- pop = if_valid & id_ready.
- push = ~redirect_valid & (count<FIFO_DEPTH | pop).
- On push, write {fetch_pc, imem_rdata} at wr_ptr, then fetch_pc <= fetch_pc+4. Wrap is modulo 2^32: 0xFFFF_FFFC -> 0.
- Simultaneous push and pop when full is legal; count is unchanged.
- if_valid = (count!=0) & ~redirect_valid.
- When empty: if_instr=NOP, if_pc=0. Otherwise both come from the head entry, combinationally.
- Redirect has top priority.
  - In the redirect cycle, no push and no pop; if_valid is forced 0.
  - At the edge: count=0, pointers=0, fetch_pc <= aligned target.
  - Aligned target is redirect_pc & ~3, unless the trap option applies.
- Latency:
  - First word pushed on the first edge after rst_n rises. if_valid is 1 during the following cycle.
  - Redirect sampled at edge N: target word pushed at edge N+1, if_valid=1 after N+1. Redirect penalty is 2 cycles.
- Back-to-back redirects: the last one wins. No entry from before any redirect may ever reach decode.
- Steady state: decode always ready gives one instruction per cycle, in strict PC order.
- Decode stalled: FIFO fills to FIFO_DEPTH, then fetch_pc holds. imem_addr stays stable while stalled.
- Reset asserted mid-operation: all state clears immediately, with no dependence on clk.
- Pointers are log2(FIFO_DEPTH) bits with natural wrap. Count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 does not change fetch_pc.
  - The FIFO is still flushed.
  - misalign_err sets to 1 at that edge and stays set until reset.
  - While misalign_err=1, push is suppressed: fetch halts and if_valid stays 0.
- Undefined: low 2 bits are silently cleared, and misalign_err is tied to 0.

Test Plan:
- Reset release, id_ready=1, memory holds 00500093, 00500113, 00208463, 00A00193, 01400213 -> if_pc 0,4,8,C,10 on consecutive cycles, with matching if_instr. The first if_valid appears one cycle after rst_n rises.
- id_ready=0 for 6 cycles after reset -> exactly FIFO_DEPTH entries buffered, imem_addr held at 0x8, if_pc stays 0. Release -> pc 0,4,8,C in order with no gaps.
- Redirect to 0x10 while FIFO holds pc 8 and C -> if_valid=0 for 2 cycles, then if_pc=0x10, if_instr=01400213. Entries 8 and C are never accepted.
- Redirects to 0x20 then 0x30 on consecutive cycles -> first delivered pc is 0x30.
- fetch_pc forced near 0xFFFF_FFF8 via redirect -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Redirect to 0x0000_0006:
  - with FETCH_MISALIGN_TRAP_EN: misalign_err=1, if_valid stays 0 until rst_n pulse.
  - without it: fetch resumes at 0x4, misalign_err=0.
